acc_reduce_tree: RTL and testbench

ACC_REDUCE_TREE -- requirements
Module: acc_reduce_tree

---
 rtl/kmeans_pkg.sv | 25 ++
 rtl/acc_add_stage.sv | 55 +++++
 rtl/acc_reduce_tree.sv | 144 ++++++++++++++
 tb/tb_acc_reduce_tree.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kmeans_pkg.sv
// Shared k-means definitions: default accumulator/count widths and elaboration helpers
// used to size and lay out the accumulator reduction tree.
package kmeans_pkg;

    localparam int ACC_W_DEF = 24;
    localparam int CNT_W_DEF = 12;

    // Ceiling log2; returns 0 for n <= 1 so a single engine needs no adder levels.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Bit offset of tree level l in a flat bus holding every level back to back.
    // Level k has 2**(lvl-k) entries of mult fields, each base+k bits wide.
    function automatic int stage_off(input int l, input int lvl, input int mult, input int base);
        int r;
        r = 0;
        for (int k = 0; k < l; k++) r += (1 << (lvl - k)) * mult * (base + k);
        return r;
    endfunction

endpackage

// File: rtl/acc_add_stage.sv
// One registered level of the reduction tree: sums adjacent entry pairs per channel
// and their counts, growing each field by one bit; holds while en is low.
module acc_add_stage #(
    parameter int N_OUT  = 1,
    parameter int NUM_CH = 3,
    parameter int IN_W   = 24,
    parameter int CIN_W  = 12
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              en,
    input  logic                              in_valid,
    input  logic                              in_last,
    input  logic [2*N_OUT*NUM_CH*IN_W-1:0]    in_dat,
    input  logic [2*N_OUT*CIN_W-1:0]          in_cnt,
    output logic                              out_valid,
    output logic                              out_last,
    output logic [N_OUT*NUM_CH*(IN_W+1)-1:0]  out_dat,
    output logic [N_OUT*(CIN_W+1)-1:0]        out_cnt
);

    logic [N_OUT*NUM_CH*(IN_W+1)-1:0] dat_nxt;
    logic [N_OUT*(CIN_W+1)-1:0]       cnt_nxt;

    // Output entry i is the sum of input entries 2i and 2i+1.
    always_comb begin
        dat_nxt = '0;
        cnt_nxt = '0;
        for (int i = 0; i < N_OUT; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                dat_nxt[(i*NUM_CH+c)*(IN_W+1) +: IN_W+1] =
                    {1'b0, in_dat[((2*i)*NUM_CH+c)*IN_W +: IN_W]} +
                    {1'b0, in_dat[((2*i+1)*NUM_CH+c)*IN_W +: IN_W]};
            end
            cnt_nxt[i*(CIN_W+1) +: CIN_W+1] =
                {1'b0, in_cnt[(2*i)*CIN_W +: CIN_W]} +
                {1'b0, in_cnt[(2*i+1)*CIN_W +: CIN_W]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_dat   <= '0;
            out_cnt   <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            out_last  <= in_last;
            out_dat   <= dat_nxt;
            out_cnt   <= cnt_nxt;
        end
    end

endmodule

// File: rtl/acc_reduce_tree.sv
// Pipelined adder tree reducing per-engine channel accumulators and pixel counts.
// Optional out_empty flag is built when ACC_REDUCE_EMPTY_FLAG_EN is defined.
module acc_reduce_tree
    import kmeans_pkg::*;
#(
    parameter int NUM_ENG = 4,
    parameter int NUM_CH  = 3,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    localparam int LVL    = clog2(NUM_ENG),
    localparam int SW     = ACC_W + LVL,
    localparam int CW     = CNT_W + LVL
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_last,
    input  logic [NUM_ENG*NUM_CH*ACC_W-1:0] ac,
    input  logic [NUM_ENG*CNT_W-1:0]    co,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic [NUM_CH*SW-1:0]        sum,
    output logic [CW-1:0]               co_sum,
    output logic [15:0]                 frame_cnt
`ifdef ACC_REDUCE_EMPTY_FLAG_EN
    ,
    output logic                        out_empty
`endif
);

    // Handshake: a beat moves on any edge where in_valid && in_ready (resp.
    // out_valid && out_ready); the whole pipe advances together or stalls together.
    localparam int NUM_LEAF = 1 << LVL;
    localparam int DAT_TOT  = stage_off(LVL + 1, LVL, NUM_CH, ACC_W);
    localparam int CNT_TOT  = stage_off(LVL + 1, LVL, 1, CNT_W);
    localparam int FIN_DOFF = stage_off(LVL, LVL, NUM_CH, ACC_W);
    localparam int FIN_COFF = stage_off(LVL, LVL, 1, CNT_W);

    logic adv;

    wire [DAT_TOT-1:0] dat;
    wire [CNT_TOT-1:0] cnt;
    wire [LVL:0]       vld;
    wire [LVL:0]       lst;

    logic [NUM_LEAF*NUM_CH*ACC_W-1:0] leaf_dat;
    logic [NUM_LEAF*CNT_W-1:0]        leaf_cnt;
    logic [NUM_LEAF*NUM_CH*ACC_W-1:0] s0_dat;
    logic [NUM_LEAF*CNT_W-1:0]        s0_cnt;
    logic                             s0_vld;
    logic                             s0_lst;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Leaves beyond NUM_ENG are tied to zero so a non-power-of-two count adds nothing.
    always_comb begin
        leaf_dat = '0;
        leaf_cnt = '0;
        for (int e = 0; e < NUM_ENG; e++) begin
            leaf_dat[e*NUM_CH*ACC_W +: NUM_CH*ACC_W] = ac[e*NUM_CH*ACC_W +: NUM_CH*ACC_W];
            leaf_cnt[e*CNT_W +: CNT_W]               = co[e*CNT_W +: CNT_W];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s0_vld <= 1'b0;
            s0_lst <= 1'b0;
            s0_dat <= '0;
            s0_cnt <= '0;
        end else if (adv) begin
            s0_vld <= in_valid;
            s0_lst <= in_last;
            s0_dat <= leaf_dat;
            s0_cnt <= leaf_cnt;
        end
    end

    assign dat[NUM_LEAF*NUM_CH*ACC_W-1:0] = s0_dat;
    assign cnt[NUM_LEAF*CNT_W-1:0]        = s0_cnt;
    assign vld[0]                         = s0_vld;
    assign lst[0]                         = s0_lst;

    for (genvar l = 1; l <= LVL; l++) begin : g_lvl
        localparam int N_OUT = 1 << (LVL - l);
        localparam int I_DOFF = stage_off(l - 1, LVL, NUM_CH, ACC_W);
        localparam int O_DOFF = stage_off(l, LVL, NUM_CH, ACC_W);
        localparam int I_COFF = stage_off(l - 1, LVL, 1, CNT_W);
        localparam int O_COFF = stage_off(l, LVL, 1, CNT_W);

        acc_add_stage #(
            .N_OUT  (N_OUT),
            .NUM_CH (NUM_CH),
            .IN_W   (ACC_W + l - 1),
            .CIN_W  (CNT_W + l - 1)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .en        (adv),
            .in_valid  (vld[l-1]),
            .in_last   (lst[l-1]),
            .in_dat    (dat[I_DOFF +: 2*N_OUT*NUM_CH*(ACC_W+l-1)]),
            .in_cnt    (cnt[I_COFF +: 2*N_OUT*(CNT_W+l-1)]),
            .out_valid (vld[l]),
            .out_last  (lst[l]),
            .out_dat   (dat[O_DOFF +: N_OUT*NUM_CH*(ACC_W+l)]),
            .out_cnt   (cnt[O_COFF +: N_OUT*(CNT_W+l)])
        );
    end

    assign out_valid = vld[LVL];
    assign out_last  = lst[LVL];
    assign sum       = dat[FIN_DOFF +: NUM_CH*SW];
    assign co_sum    = cnt[FIN_COFF +: CW];

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (out_valid && out_ready && out_last) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

`ifdef ACC_REDUCE_EMPTY_FLAG_EN
    // Counts are unsigned, so the total is zero exactly when every leaf count is zero;
    // that bit rides alongside the data to land with the final stage.
    logic [LVL:0] emp_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            emp_q <= '0;
        end else if (adv) begin
            emp_q[0] <= (co == '0);
            for (int i = 1; i <= LVL; i++) emp_q[i] <= emp_q[i-1];
        end
    end

    assign out_empty = emp_q[LVL];
`endif

endmodule

// File: tb/tb_acc_reduce_tree.sv
// Self-checking bench for acc_reduce_tree: scoreboarded 4-engine instance plus a
// 3-engine instance for the padded-leaf boundary case.
module tb_acc_reduce_tree;

    localparam int NE    = 4;
    localparam int NC    = 3;
    localparam int AW    = 24;
    localparam int CWI   = 12;
    localparam int LV    = 2;
    localparam int SW    = AW + LV;
    localparam int CW    = CWI + LV;
    localparam int AC_W  = NE * NC * AW;
    localparam int CO_W  = NE * CWI;
    localparam int SUM_W = NC * SW;
    localparam int E_W   = 1 + CW + SUM_W;
    localparam int AC3_W = 3 * NC * AW;
    localparam int CO3_W = 3 * CWI;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic              in_valid, in_ready, in_last;
    logic [AC_W-1:0]   ac;
    logic [CO_W-1:0]   co;
    logic              out_valid, out_ready, out_last;
    logic [SUM_W-1:0]  sum;
    logic [CW-1:0]     co_sum;
    logic [15:0]       frame_cnt;

    logic              in_valid3, in_ready3, in_last3;
    logic [AC3_W-1:0]  ac3;
    logic [CO3_W-1:0]  co3;
    logic              out_valid3, out_ready3, out_last3;
    logic [SUM_W-1:0]  sum3;
    logic [CW-1:0]     co_sum3;
    logic [15:0]       frame_cnt3;
`ifdef ACC_REDUCE_EMPTY_FLAG_EN
    logic              out_empty, out_empty3;
`endif

    acc_reduce_tree #(.NUM_ENG(NE), .NUM_CH(NC), .ACC_W(AW), .CNT_W(CWI)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .ac(ac), .co(co), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .sum(sum), .co_sum(co_sum),
        .frame_cnt(frame_cnt)
`ifdef ACC_REDUCE_EMPTY_FLAG_EN
        , .out_empty(out_empty)
`endif
    );

    acc_reduce_tree #(.NUM_ENG(3), .NUM_CH(NC), .ACC_W(AW), .CNT_W(CWI)) dut3 (
        .clk(clk), .reset(reset), .in_valid(in_valid3), .in_ready(in_ready3),
        .in_last(in_last3), .ac(ac3), .co(co3), .out_valid(out_valid3),
        .out_ready(out_ready3), .out_last(out_last3), .sum(sum3), .co_sum(co_sum3),
        .frame_cnt(frame_cnt3)
`ifdef ACC_REDUCE_EMPTY_FLAG_EN
        , .out_empty(out_empty3)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [E_W-1:0] exp_q[$];
    int ready_mode = 0;   // 0: always ready, 1: random, 2: held low

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [E_W-1:0] model(input logic [AC_W-1:0] a, input logic [CO_W-1:0] c,
                                             input logic l);
        logic [SW-1:0]  s[NC];
        logic [CW-1:0]  cs;
        logic [E_W-1:0] r;
        cs = '0;
        for (int ch = 0; ch < NC; ch++) s[ch] = '0;
        for (int e = 0; e < NE; e++) begin
            for (int ch = 0; ch < NC; ch++) s[ch] += SW'(a[(e*NC+ch)*AW +: AW]);
            cs += CW'(c[e*CWI +: CWI]);
        end
        r = '0;
        for (int ch = 0; ch < NC; ch++) r[ch*SW +: SW] = s[ch];
        r[SUM_W +: CW] = cs;
        r[E_W-1] = l;
        return r;
    endfunction

    task automatic send(input logic [AC_W-1:0] a, input logic [CO_W-1:0] c, input logic l);
        int w;
        in_valid = 1'b1;
        ac = a;
        co = c;
        in_last = l;
        exp_q.push_back(model(a, c, l));
        w = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            w++;
            if (w > 200) begin
                check("in_ready_timeout", in_ready, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 1;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 200) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0) out_ready = 1'b1;
            else if (ready_mode == 2) out_ready = 1'b0;
            else out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Scoreboard and stall-stability monitor, sampled mid-cycle.
    logic           prev_stall = 1'b0;
    logic [E_W-1:0] prev_out;
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", {out_last, co_sum, sum}, prev_out);
            end
            if (out_valid && out_ready) begin
                check("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("beat_data", {out_last, co_sum, sum}, exp_q.pop_front());
            end
            prev_stall = out_valid && !out_ready;
            prev_out = {out_last, co_sum, sum};
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AC_W-1:0] a;
        logic [CO_W-1:0] c;
        logic [E_W-1:0]  ea;
        int n;

        in_valid = 1'b0; in_last = 1'b0; ac = '0; co = '0;
        in_valid3 = 1'b0; in_last3 = 1'b0; ac3 = '0; co3 = '0; out_ready3 = 1'b1;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_co_sum", co_sum, 0);
        check("rst_out_last", out_last, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_frame_cnt", frame_cnt, 0);
        @(posedge clk);
        #1;

        // Known-answer beat and pipeline latency.
        a = '0; c = '0;
        for (int e = 0; e < NE; e++) begin
            a[(e*NC+0)*AW +: AW] = AW'(e + 1);
            a[(e*NC+1)*AW +: AW] = AW'(10 * (e + 1));
            a[(e*NC+2)*AW +: AW] = AW'(100 * (e + 1));
            c[e*CWI +: CWI] = CWI'(e + 5);
        end
        send(a, c, 1'b1);
        wait_valid(n);
        check("latency", n, LV + 1);
        check("r_sum", sum[0*SW +: SW], 10);
        check("g_sum", sum[1*SW +: SW], 100);
        check("b_sum", sum[2*SW +: SW], 1000);
        check("co_sum_kat", co_sum, 26);
        drain();
        check("frame_cnt_one", frame_cnt, 1);

        // Random beats with bubbles and random backpressure.
        ready_mode = 1;
        for (int i = 0; i < 40; i++) begin
            if (i % 10 == 9) begin
                a = '1; c = '1;
            end else begin
                for (int k = 0; k < AC_W; k++) a[k] = 1'($urandom_range(0, 1));
                for (int k = 0; k < CO_W; k++) c[k] = 1'($urandom_range(0, 1));
            end
            send(a, c, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        ready_mode = 0;
        drain();

        // Padded-leaf case on the three-engine instance.
        ac3 = '1; co3 = '1; in_valid3 = 1'b1; in_last3 = 1'b1;
        @(posedge clk);
        #1 in_valid3 = 1'b0;
        n = 1;
        while (!out_valid3 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("eng3_latency", n, 3);
        for (int ch = 0; ch < NC; ch++) check("eng3_sum", sum3[ch*SW +: SW], 26'h2FFFFFD);
        check("eng3_co_sum", co_sum3, 14'h2FFD);

        // Back-to-back A,B,C with downstream stalled once A appears.
        ready_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < AC_W; k++) a[k] = 1'($urandom_range(0, 1));
        c = CO_W'(48'h123456789ABC);
        ea = model(a, c, 1'b0);
        send(a, c, 1'b0);
        send(~a, ~c, 1'b0);
        send(a ^ {AC_W{1'b1}} >> 3, c >> 5, 1'b1);
        check("stall_a_valid", out_valid, 1);
        check("stall_a_data", {out_last, co_sum, sum}, ea);
        repeat (4) begin
            @(negedge clk);
            check("stall_in_ready", in_ready, 0);
            check("stall_out_valid", out_valid, 1);
        end
        @(posedge clk);
        #1 ready_mode = 0;
        drain();

        // Reset with two beats in flight.
        send(a, c, 1'b1);
        send(~a, c, 1'b1);
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_flight_valid", out_valid, 0);
        end
        check("rst_flight_frame", frame_cnt, 0);
        @(posedge clk);
        #1;

        // Frame counter wrap over 65537 single-beat frames.
        for (int i = 0; i < 65537; i++) begin
            a = AC_W'(i * 7);
            c = CO_W'(i);
            send(a, c, 1'b1);
        end
        drain();
        check("frame_wrap", frame_cnt, 1);

`ifdef ACC_REDUCE_EMPTY_FLAG_EN
        send(a, '0, 1'b0);
        wait_valid(n);
        check("empty_set", out_empty, 1);
        drain();
        c = '0; c[0] = 1'b1;
        send(a, c, 1'b0);
        wait_valid(n);
        check("empty_clear", out_empty, 0);
        drain();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
